// File: rtl/mc8051_biu_ws.sv
// Wait-state-aware bus interface unit for the mc8051 core: one registered memory access
// per phase slot, core stall while memory is busy, and abort after a programmable wait limit.
module mc8051_biu_ws #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned PH_W     = 4,
    parameter int unsigned PH_S1    = 0,
    parameter int unsigned PH_S2    = 2,
    parameter int unsigned PH_S3    = 4,
    parameter int unsigned PH_S6    = 10,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [PH_W-1:0]   i_t_p_d,
    input  logic              i_we_n,
    input  logic              i_rd_n,
    input  logic              i_psen_n,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [ADDR_W-1:0] i_s2_addr,
    input  logic [ADDR_W-1:0] i_s3_addr,
    input  logic [ADDR_W-1:0] i_s6_addr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    output logic              o_data_rdy,
    output logic [DATA_W-1:0] o_mem_rdata,
    output logic              o_stall,
    output logic              o_timeout,
    output logic              o_bus_err,
    output logic              mem_we_n,
    output logic              mem_rd_n,
    output logic              mem_psen_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_data_rdy,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_ACC  = 1'b1;

    localparam logic [7:0] CNT_LAST = 8'(WAIT_MAX - 1);

    logic              state;
    logic [7:0]        wait_cnt;
    logic [PH_W-1:0]   prev_phase;

    logic              is_s1, is_s2, is_s3, is_s6;
    logic              slot_entry;
    logic [1:0]        req_cnt;
    logic              illegal;
    logic [ADDR_W-1:0] slot_addr;

    always_comb begin
        is_s1      = (i_t_p_d == PH_W'(PH_S1));
        is_s2      = (i_t_p_d == PH_W'(PH_S2));
        is_s3      = (i_t_p_d == PH_W'(PH_S3));
        is_s6      = (i_t_p_d == PH_W'(PH_S6));
        // prev_phase compare makes a phase held during stall count as a single entry
        slot_entry = (is_s1 | is_s2 | is_s3 | is_s6) && (i_t_p_d != prev_phase);
        req_cnt    = {1'b0, ~i_we_n} + {1'b0, ~i_rd_n} + {1'b0, ~i_psen_n};
        illegal    = (req_cnt > 2'd1) || (!i_we_n && !is_s6);
        slot_addr  = i_pc;
        if (is_s2)      slot_addr = i_s2_addr;
        else if (is_s3) slot_addr = i_s3_addr;
        else if (is_s6) slot_addr = i_s6_addr;
    end

    assign o_stall = (state == ST_ACC) && !mem_data_rdy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            prev_phase  <= '1;
            mem_addr    <= '0;
            mem_wdata   <= '1;
            o_mem_rdata <= '1;
            mem_we_n    <= 1'b1;
            mem_rd_n    <= 1'b1;
            mem_psen_n  <= 1'b1;
            o_data_rdy  <= 1'b0;
            o_timeout   <= 1'b0;
            o_bus_err   <= 1'b0;
        end else begin
            prev_phase <= i_t_p_d;
            o_data_rdy <= 1'b0;
            o_timeout  <= 1'b0;
            o_bus_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (slot_entry) begin
                        if (illegal) begin
                            o_bus_err <= 1'b1;
                        end else if (req_cnt == 2'd1) begin
                            mem_addr   <= slot_addr;
                            mem_we_n   <= i_we_n;
                            mem_rd_n   <= i_rd_n;
                            mem_psen_n <= i_psen_n;
                            if (!i_we_n) mem_wdata <= i_mem_wdata;
                            wait_cnt   <= '0;
                            state      <= ST_ACC;
                        end
                    end
                end
                default: begin
                    if (slot_entry) o_bus_err <= 1'b1;
                    if (mem_data_rdy) begin
                        if (!mem_rd_n || !mem_psen_n) o_mem_rdata <= mem_rdata;
                        mem_we_n   <= 1'b1;
                        mem_rd_n   <= 1'b1;
                        mem_psen_n <= 1'b1;
                        o_data_rdy <= 1'b1;
                        state      <= ST_IDLE;
                    end else if (wait_cnt == CNT_LAST) begin
                        mem_we_n    <= 1'b1;
                        mem_rd_n    <= 1'b1;
                        mem_psen_n  <= 1'b1;
                        o_mem_rdata <= '1;
                        o_data_rdy  <= 1'b1;
                        o_timeout   <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule
